demux_tdm_1to8: RTL and testbench

// Receive-side counterpart of the 8:1 channel mux: takes the 1-bit time-division

---
 rtl/demux_tdm_1to8.sv | 147 ++++++++++++++
 tb/tb_demux_tdm_1to8.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/demux_tdm_1to8.sv
// demux_tdm_1to8
// Rebuilds NUM_CH parallel channel bits from a 1-bit TDM stream.
// A HUNT/RUN framer tracks the slot index. Slot 0 is marked by sync.
// Slots 0..NUM_CH-2 are collected in a shadow register. The final slot bit
// is merged straight into out, so a complete frame is published on the same
// edge that samples its last bit.
module demux_tdm_1to8 #(
    parameter int NUM_CH   = 8,
    parameter int SEL_W    = 3,
    parameter bit SYNC_REQ = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw,
    input  logic              din,
    input  logic              din_valid,
    input  logic              sync,
    output logic [NUM_CH-1:0] out,
    output logic              frame_valid,
    output logic [SEL_W-1:0]  slot,
    output logic              locked,
    output logic              sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0] ONE_SLOT  = SEL_W'(1);

    state_t              state_reg;
    logic [SEL_W-1:0]    slot_reg;
    logic [NUM_CH-2:0]   shadow_reg;
    logic [NUM_CH-1:0]   out_reg;
    logic                frame_valid_reg;
    logic                sync_err_reg;
    logic                locked_reg;

    // Per-cycle event decode. Every event is gated by sw and din_valid.
    logic                accept;
    logic                in_run;
    logic                slot_zero;
    logic                start_frame;   // bit becomes slot 0 of a new frame
    logic                mid_write;     // bit lands in slot 1..NUM_CH-1
    logic                last_write;    // bit completes the frame
    logic                missing_sync;  // slot 0 arrived without sync
    logic                early_sync;    // sync arrived before the frame finished
    logic [NUM_CH-2:0]   shadow_we;

    assign accept       = sw && din_valid;
    assign in_run       = (state_reg == RUN);
    assign slot_zero    = (slot_reg == '0);
    // When sync is not required, a slot-0 bit without sync still opens the next frame.
    assign start_frame  = accept && (sync || (in_run && slot_zero && !SYNC_REQ));
    assign mid_write    = accept && in_run && !sync && !slot_zero;
    assign last_write   = mid_write && (slot_reg == LAST_SLOT);
    assign missing_sync = accept && in_run && slot_zero && !sync && SYNC_REQ;
    assign early_sync   = accept && in_run && !slot_zero && sync;

    // Shadow bits, one write enable per slot. Each slot is rewritten every frame,
    // so the shadow register is never cleared between frames.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH - 1; gi++) begin : g_shadow
            if (gi == 0) begin : g_first
                assign shadow_we[gi] = start_frame;
            end else begin : g_rest
                assign shadow_we[gi] = mid_write && (slot_reg == SEL_W'(gi));
            end

            // Capture din into this slot's shadow bit when the slot is written.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= 1'b0;
                end else if (shadow_we[gi]) begin
                    shadow_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // Framing FSM with the registered slot counter, output frame and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= HUNT;
            slot_reg        <= '0;
            out_reg         <= '0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            if (!sw) begin
                // Disabled: drop any partial frame. The last published frame is kept.
                state_reg  <= HUNT;
                slot_reg   <= '0;
                locked_reg <= 1'b0;
            end else if (din_valid) begin
                unique case (state_reg)
                    HUNT: begin
                        // Bits without sync are discarded silently while hunting.
                        if (sync) begin
                            state_reg  <= RUN;
                            slot_reg   <= ONE_SLOT;
                            locked_reg <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (start_frame) begin
                            // A normal frame start, or a restart on early sync.
                            // An early sync abandons the partial frame.
                            slot_reg     <= ONE_SLOT;
                            sync_err_reg <= early_sync;
                        end else if (missing_sync) begin
                            state_reg    <= HUNT;
                            slot_reg     <= '0;
                            locked_reg   <= 1'b0;
                            sync_err_reg <= 1'b1;
                        end else begin
                            // Wraps to 0 after the last slot.
                            slot_reg <= slot_reg + ONE_SLOT;
                            if (last_write) begin
                                out_reg         <= {din, shadow_reg};
                                frame_valid_reg <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= HUNT;
                        slot_reg   <= '0;
                        locked_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out         = out_reg;
    assign frame_valid = frame_valid_reg;
    assign slot        = slot_reg;
    assign locked      = locked_reg;
    assign sync_err    = sync_err_reg;

endmodule

// File: tb/tb_demux_tdm_1to8.sv
// Directed bench for demux_tdm_1to8. It covers reset, nominal and back-to-back
// frames, early and missing sync, gaps, the enable (sw) and a mid-frame reset.
module tb_demux_tdm_1to8;

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic       din;
    logic       din_valid;
    logic       sync;
    logic [7:0] out;
    logic       frame_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;

    int checks   = 0;
    int failures = 0;

    demux_tdm_1to8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .out        (out),
        .frame_valid(frame_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle, then wait until just after the sampling edge.
    task automatic drive(input logic v, input logic s, input logic d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    // Send slots first..last of frame v, with sync on slot 0. An optional idle
    // cycle follows each bit. The task checks the slot counter, lock and output.
    task automatic frame_bits(input logic [7:0] v, input int first, input int last,
                              input bit gap, input logic [7:0] prev_out);
        for (int k = first; k <= last; k++) begin
            drive(1'b1, (k == 0), v[k]);
            chk($sformatf("slot_after_bit%0d", k), {29'd0, slot}, (k + 1) % 8);
            chk($sformatf("locked_bit%0d", k), {31'd0, locked}, 1);
            chk($sformatf("sync_err_bit%0d", k), {31'd0, sync_err}, 0);
            if (k < 7) begin
                chk($sformatf("fv_low_bit%0d", k), {31'd0, frame_valid}, 0);
                chk($sformatf("out_hold_bit%0d", k), {24'd0, out}, {24'd0, prev_out});
            end else begin
                chk("fv_pulse", {31'd0, frame_valid}, 1);
                chk("out_frame", {24'd0, out}, {24'd0, v});
            end
            if (gap) begin
                drive(1'b0, 1'b0, ~v[k]);
                chk($sformatf("gap_slot%0d", k), {29'd0, slot}, (k + 1) % 8);
                chk($sformatf("gap_fv%0d", k), {31'd0, frame_valid}, 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sw = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0;

        // 1: reset held with random activity on the inputs
        for (int i = 0; i < 5; i++) begin
            sw = 1'b1;
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("rst_out", {24'd0, out}, 0);
            chk("rst_slot", {29'd0, slot}, 0);
            chk("rst_locked", {31'd0, locked}, 0);
            chk("rst_pulses", {30'd0, frame_valid, sync_err}, 0);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // 2: nominal frame, bits 1,1,0,0,1,1,0,0 -> 0x33
        frame_bits(8'h33, 0, 7, 1'b0, 8'h00);
        // 3: back-to-back frame 0xA5, no gap
        frame_bits(8'hA5, 0, 7, 1'b0, 8'h33);

        // 4: early sync at slot 4; a clean frame 0x5C follows from that sync
        frame_bits(8'hFF, 0, 3, 1'b0, 8'hA5);
        drive(1'b1, 1'b1, 1'b0);   // 0x5C bit 0
        chk("early_sync_err", {31'd0, sync_err}, 1);
        chk("early_out_hold", {24'd0, out}, 8'hA5);
        chk("early_fv", {31'd0, frame_valid}, 0);
        chk("early_slot", {29'd0, slot}, 1);
        chk("early_locked", {31'd0, locked}, 1);
        frame_bits(8'h5C, 1, 7, 1'b0, 8'hA5);

        // 5: missing sync on slot 0
        drive(1'b1, 1'b0, 1'b1);
        chk("miss_sync_err", {31'd0, sync_err}, 1);
        chk("miss_locked", {31'd0, locked}, 0);
        chk("miss_slot", {29'd0, slot}, 0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'(i & 1));
            chk("hunt_locked", {31'd0, locked}, 0);
            chk("hunt_out", {24'd0, out}, 8'h5C);
            chk("hunt_pulses", {30'd0, frame_valid, sync_err}, 0);
        end

        // 6a: 0x33 with an idle cycle after every bit
        frame_bits(8'h33, 0, 7, 1'b1, 8'h5C);

        // 6b: sw drops at slot 5; the rest of the frame is ignored
        frame_bits(8'hFF, 0, 4, 1'b0, 8'h33);
        sw = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        chk("sw_slot", {29'd0, slot}, 0);
        chk("sw_locked", {31'd0, locked}, 0);
        sw = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("sw_no_fv", {31'd0, frame_valid}, 0);
        chk("sw_out_hold", {24'd0, out}, 8'h33);

        // 6c: sw falls in the same cycle as the last slot bit
        frame_bits(8'hF0, 0, 6, 1'b0, 8'h33);
        sw = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        chk("sw_last_fv", {31'd0, frame_valid}, 0);
        chk("sw_last_out", {24'd0, out}, 8'h33);
        sw = 1'b1;

        // 6d: asynchronous reset at slot 3, with no frame until a new sync
        frame_bits(8'h0F, 0, 2, 1'b0, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {24'd0, out}, 0);
        chk("async_rst_slot", {29'd0, slot}, 0);
        chk("async_rst_locked", {31'd0, locked}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 3; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            chk("post_rst_locked", {31'd0, locked}, 0);
            chk("post_rst_fv", {31'd0, frame_valid}, 0);
        end
        chk("post_rst_out", {24'd0, out}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
